// File: rtl/spm_driver.sv
// Host-side driver for the serial-parallel multiplier: loads x in parallel, streams y
// LSB-first with sign/zero extension, and deserializes the serial product into out_p.
module spm_driver #(
  parameter int WIDTH  = 32,
  parameter int PLAT   = 1,
  parameter bit SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  output logic [WIDTH-1:0]     spm_x,
  output logic                 spm_y,
  output logic                 spm_clr,
  input  logic                 spm_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW + PLAT + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(PW - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(PW + PLAT - 1);
  localparam logic [CW-1:0] CAP_FIRST  = CW'(PLAT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] spm_x_q, spm_x_d;
  logic             spm_y_q, spm_y_d;
  logic             spm_clr_q, spm_clr_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    out_p_q, out_p_d;
  logic             cap_s;

  // State, counter and registered-output update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      fill_q      <= 1'b0;
      spm_x_q     <= '0;
      spm_y_q     <= 1'b0;
      spm_clr_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      fill_q      <= fill_d;
      spm_x_q     <= spm_x_d;
      spm_y_q     <= spm_y_d;
      spm_clr_q   <= spm_clr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    fill_d      = fill_q;
    spm_x_d     = spm_x_q;
    spm_y_d     = 1'b0;
    spm_clr_d   = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    cap_s       = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          spm_x_d    = in_x;
          sh_d       = in_y;
          fill_d     = in_y[WIDTH-1] & SIGNED;
          in_ready_d = 1'b0;
          spm_clr_d  = 1'b1;
          state_d    = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CLEAR: begin
        cnt_d   = '0;
        spm_y_d = sh_q[0];
        sh_d    = {fill_q, sh_q[WIDTH-1:1]};
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        cnt_d = cnt_q + CNT_ONE;
        cap_s = (cnt_q >= CAP_FIRST);
        if (cnt_q == SHIFT_LAST) begin
          // Extension bit keeps flowing while the pipelined tail drains
          state_d     = (PLAT == 0) ? S_DONE : S_DRAIN;
          out_valid_d = (PLAT == 0);
          spm_y_d     = (PLAT == 0) ? 1'b0 : fill_q;
        end else begin
          spm_y_d = sh_q[0];
          sh_d    = {fill_q, sh_q[WIDTH-1:1]};
        end
      end

      S_DRAIN: begin
        cnt_d = cnt_q + CNT_ONE;
        cap_s = 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else begin
          spm_y_d = fill_q;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cnt_d       = '0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase

    if (cap_s) begin
      out_p_d = {spm_p, out_p_q[PW-1:1]};
    end else begin
      out_p_d = out_p_q;
    end
  end

  assign in_ready  = in_ready_q;
  assign spm_x     = spm_x_q;
  assign spm_y     = spm_y_q;
  assign spm_clr   = spm_clr_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

endmodule

// File: tb/tb_spm_driver.sv
// Bench for spm_driver: signed (A) and unsigned (B) instances, each closed over a
// behavioural spm model; expected products go through a scoreboard queue.
module tb_spm_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       in_valid_a, in_ready_a, spm_y_a, spm_clr_a, spm_p_a, out_valid_a, out_ready_a;
  logic [7:0] in_x_a, in_y_a, spm_x_a;
  logic [15:0] out_p_a;
  logic       in_valid_b, in_ready_b, spm_y_b, spm_clr_b, spm_p_b, out_valid_b, out_ready_b;
  logic [7:0] in_x_b, in_y_b, spm_x_b;
  logic [15:0] out_p_b;

  spm_driver #(.WIDTH(8), .PLAT(1), .SIGNED(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_x(in_x_a), .in_y(in_y_a), .spm_x(spm_x_a), .spm_y(spm_y_a),
    .spm_clr(spm_clr_a), .spm_p(spm_p_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_p(out_p_a));

  spm_driver #(.WIDTH(8), .PLAT(1), .SIGNED(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_x(in_x_b), .in_y(in_y_b), .spm_x(spm_x_b), .spm_y(spm_y_b),
    .spm_clr(spm_clr_b), .spm_p(spm_p_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_p(out_p_b));

  // Behavioural spm: emits product bit k one cycle after y bit k, accumulator shifts right
  logic signed [17:0] acc_a, acc_b, sum_a, sum_b;
  always_comb begin
    sum_a = acc_a + (spm_y_a ? {{10{spm_x_a[7]}}, spm_x_a} : 18'd0);
    sum_b = acc_b + (spm_y_b ? {10'd0, spm_x_b} : 18'd0);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_a <= '0; acc_b <= '0; spm_p_a <= 1'b0; spm_p_b <= 1'b0;
    end else begin
      if (spm_clr_a) begin acc_a <= '0; spm_p_a <= 1'b0; end
      else begin acc_a <= sum_a >>> 1; spm_p_a <= sum_a[0]; end
      if (spm_clr_b) begin acc_b <= '0; spm_p_b <= 1'b0; end
      else begin acc_b <= sum_b >>> 1; spm_p_b <= sum_b[0]; end
    end
  end

  logic [15:0] sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input bit sgn);
    logic [15:0] xe, ye;
    xe = sgn ? {{8{x[7]}}, x} : {8'h00, x};
    ye = sgn ? {{8{y[7]}}, y} : {8'h00, y};
    return xe * ye;
  endfunction

  // Called just after an accepting edge: tracks clr/y activity, latency and result
  task automatic wait_result(input bit sel, input bit release_o, output int ones_lo, output int ones_hi);
    int lat, clr;
    logic [15:0] exp_p;
    lat = 0; clr = 0; ones_lo = 0; ones_hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sel ? spm_clr_b : spm_clr_a) clr++;
      if (i >= 1 && i <= 8 && (sel ? spm_y_b : spm_y_a)) ones_lo++;
      if (i >= 9 && i <= 16 && (sel ? spm_y_b : spm_y_a)) ones_hi++;
      if (sel ? out_valid_b : out_valid_a) break;
      @(posedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd18);
    check("clr_cycles", 32'(clr), 32'd1);
    check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
    exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 16'h0000;
    check("out_p", {16'h0000, sel ? out_p_b : out_p_a}, {16'h0000, exp_p});
    if (release_o) begin
      if (sel) out_ready_b = 1'b1; else out_ready_a = 1'b1;
      @(posedge clk); #1;
      check("rel_out_valid", {31'd0, sel ? out_valid_b : out_valid_a}, 32'd0);
      check("rel_in_ready", {31'd0, sel ? in_ready_b : in_ready_a}, 32'd1);
      if (sel) out_ready_b = 1'b0; else out_ready_a = 1'b0;
    end
  endtask

  task automatic run_op(input bit sel, input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp,
                        input bit release_o, output int ones_lo, output int ones_hi);
    bit got;
    @(posedge clk); #1;
    if (sel) begin in_valid_b = 1'b1; in_x_b = x; in_y_b = y; end
    else begin in_valid_a = 1'b1; in_x_a = x; in_y_a = y; end
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sel ? in_ready_b : in_ready_a) begin got = 1'b1; break; end
    end
    check("accept_ready", {31'd0, got}, 32'd1);
    @(posedge clk);
    sb_q.push_back(exp);
    #1;
    if (sel) in_valid_b = 1'b0; else in_valid_a = 1'b0;
    wait_result(sel, release_o, ones_lo, ones_hi);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx, ry;
    logic [15:0] snap;
    int lo, hi, lat;
    rst = 1'b0;
    in_valid_a = 1'b0; in_x_a = 8'h00; in_y_a = 8'h00; out_ready_a = 1'b0;
    in_valid_b = 1'b0; in_x_b = 8'h00; in_y_b = 8'h00; out_ready_b = 1'b0;

    #12;
    check("rst_in_ready", {31'd0, in_ready_a}, 32'd0);
    check("rst_spm_x", {24'd0, spm_x_a}, 32'd0);
    check("rst_spm_y", {31'd0, spm_y_a}, 32'd0);
    check("rst_spm_clr", {31'd0, spm_clr_a}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("rst_out_p", {16'd0, out_p_a}, 32'd0);
    @(negedge clk); rst = 1'b1;
    #1;
    check("rel_rst_in_ready_low", {31'd0, in_ready_a}, 32'd0);
    @(posedge clk); #1;
    check("rel_rst_in_ready_high", {31'd0, in_ready_a}, 32'd1);

    run_op(1'b0, 8'h03, 8'h05, 16'h000F, 1'b1, lo, hi);
    run_op(1'b0, 8'hFE, 8'h03, 16'hFFFA, 1'b1, lo, hi);
    run_op(1'b0, 8'hFF, 8'hFF, 16'h0001, 1'b1, lo, hi);
    check("signed_ext_ones", 32'(hi), 32'd8);
    run_op(1'b0, 8'h80, 8'h80, 16'h4000, 1'b1, lo, hi);
    run_op(1'b0, 8'h00, 8'h5A, 16'h0000, 1'b1, lo, hi);
    run_op(1'b0, 8'h7B, 8'h00, 16'h0000, 1'b1, lo, hi);

    run_op(1'b1, 8'hFF, 8'hFF, 16'hFE01, 1'b1, lo, hi);
    check("unsigned_y_lo_ones", 32'(lo), 32'd8);
    check("unsigned_y_ext_zero", 32'(hi), 32'd0);

    // out_ready held high through the whole operation must not cut it short
    out_ready_a = 1'b1;
    run_op(1'b0, 8'h0C, 8'hF3, ref_mul(8'h0C, 8'hF3, 1'b1), 1'b1, lo, hi);

    for (int k = 0; k < 3; k++) begin
      rx = 8'($urandom_range(0, 255)); ry = 8'($urandom_range(0, 255));
      run_op(1'b0, rx, ry, ref_mul(rx, ry, 1'b1), 1'b1, lo, hi);
      rx = 8'($urandom_range(0, 255)); ry = 8'($urandom_range(0, 255));
      run_op(1'b1, rx, ry, ref_mul(rx, ry, 1'b0), 1'b1, lo, hi);
    end

    // Backpressure: result held while a new request is ignored
    run_op(1'b0, 8'h25, 8'hE1, ref_mul(8'h25, 8'hE1, 1'b1), 1'b0, lo, hi);
    snap = out_p_a;
    in_valid_a = 1'b1; in_x_a = 8'h11; in_y_a = 8'h22;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid_a}, 32'd1);
      check("bp_out_p", {16'd0, out_p_a}, {16'd0, snap});
      check("bp_in_ready", {31'd0, in_ready_a}, 32'd0);
    end
    in_valid_a = 1'b0;
    check("bp_spm_x_kept", {24'd0, spm_x_a}, 32'h25);
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_in_ready", {31'd0, in_ready_a}, 32'd1);
    check("bp_rel_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("bp_rel_out_p", {16'd0, out_p_a}, {16'd0, snap});
    out_ready_a = 1'b0;

    // Reset during SHIFT cycle 5
    @(posedge clk); #1;
    in_valid_a = 1'b1; in_x_a = 8'h12; in_y_a = 8'h34;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready_a}, 32'd0);
    check("mid_rst_spm_x", {24'd0, spm_x_a}, 32'd0);
    check("mid_rst_spm_y", {31'd0, spm_y_a}, 32'd0);
    check("mid_rst_spm_clr", {31'd0, spm_clr_a}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("mid_rst_out_p", {16'd0, out_p_a}, 32'd0);
    @(negedge clk); rst = 1'b1;
    #1;
    check("mid_rst_rel_low", {31'd0, in_ready_a}, 32'd0);
    @(posedge clk); #1;
    check("mid_rst_rel_high", {31'd0, in_ready_a}, 32'd1);
    run_op(1'b0, 8'h07, 8'h09, 16'h003F, 1'b1, lo, hi);

    // Back-to-back with in_valid held high
    @(posedge clk); #1;
    in_valid_a = 1'b1; in_x_a = 8'h7F; in_y_a = 8'h7F;
    @(posedge clk);
    sb_q.push_back(16'h3F01);
    #1;
    in_x_a = 8'h02; in_y_a = 8'h03;
    wait_result(1'b0, 1'b0, lo, hi);
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    check("b2b_exit_in_ready", {31'd0, in_ready_a}, 32'd1);
    check("b2b_exit_out_valid", {31'd0, out_valid_a}, 32'd0);
    out_ready_a = 1'b0;
    @(posedge clk);
    sb_q.push_back(16'h0006);
    #1;
    check("b2b_accept_in_ready", {31'd0, in_ready_a}, 32'd0);
    check("b2b_accept_spm_x", {24'd0, spm_x_a}, 32'h02);
    in_valid_a = 1'b0;
    wait_result(1'b0, 1'b1, lo, hi);
    lat = sb_q.size();
    check("sb_drained", 32'(lat), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spm_driver.md
Name: spm_driver

Overview:
- Initiator/host side of the serial-parallel multiplier (spm) datapath.
- Accepts a parallel operand pair over a valid/ready handshake, drives the multiplicand x in parallel, and streams the multiplier y into the spm LSB-first (sign-extended).
- Deserializes the spm's serial product stream back into a parallel 2*WIDTH product.
- Presents the product on an output valid/ready handshake; sits between the bus-side register block and the spm array.

Parameters:
WIDTH, 32, operand width; must match the spm x width (one csa stage per bit).
PLAT, 1, cycles from driving y bit k on spm_y to product bit k appearing on spm_p; legal range 0..3.
SIGNED, 1, 1: y sign-extended with y[WIDTH-1] after bit WIDTH-1; 0: zero-extended.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  driver idle, can accept operands
in_x  input  WIDTH  multiplicand
in_y  input  WIDTH  multiplier
spm_x  output  WIDTH  parallel multiplicand to spm, registered
spm_y  output  1  serial multiplier bit to spm, registered
spm_clr  output  1  one-cycle clear pulse to the spm accumulators before each operation
spm_p  input  1  serial product bit from spm, LSB first
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
out_p  output  2*WIDTH  parallel product

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; counters=0; outputs in_ready, spm_x, spm_y, spm_clr, out_valid, out_p all 0.
  - in_ready is a register that rises at the first clock edge after rst deasserts.
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready: latch in_x into spm_x, latch in_y into the shift register, drop in_ready, go to CLEAR.
- CLEAR: spm_clr=1 for exactly one cycle; spm_y=0; bit counter=0; go to SHIFT.
- SHIFT (2*WIDTH cycles):
  - spm_y = current LSB of the shift register; shift right each cycle.
  - Fill bit is y[WIDTH-1] if SIGNED, else 0, so cycles WIDTH..2*WIDTH-1 carry the extension.
  - After 2*WIDTH cycles go to DRAIN; if PLAT=0, go directly to DONE.
- DRAIN (PLAT cycles): spm_y holds the extension bit.
- Product capture:
  - Capture counter starts PLAT cycles after SHIFT entry.
  - Each cycle, spm_p is shifted into out_p from the MSB end (right shift), so after 2*WIDTH captures out_p[k] = product bit k.
  - Captures stop after exactly 2*WIDTH bits.
- Latency: out_valid rises 2*WIDTH+PLAT+1 clock edges after the accepting edge.
- DONE:
  - out_valid=1; out_p stable.
  - On out_ready: out_valid drops at the next edge, in_ready rises at the same edge, state returns to IDLE.
  - out_p keeps its last value until the next capture begins.
- spm_x stays constant from accept until the next accept.
- Arithmetic: the product is modulo 2^(2*WIDTH); two's complement when SIGNED=1.
- Boundary conditions:
  - in_valid asserted outside IDLE: ignored, no latch.
  - out_ready asserted outside DONE: ignored.
  - Back-to-back operations: minimum spacing is one IDLE cycle between DONE exit and the next accept.
  - rst asserted mid-operation: immediate return to IDLE; partial product discarded; spm_clr is not pulsed by reset (spm has its own reset).
  - x=0 or y=0: full sequence still runs, out_p=0.
  - x=-2^(WIDTH-1), y=-2^(WIDTH-1) with SIGNED=1: out_p=2^(2*WIDTH-2), no overflow.

Test Plan:
- WIDTH=8, PLAT=1, SIGNED=1; in_x=3, in_y=5 -> out_valid at edge 18 after accept; out_p=16'h000F; spm_clr high exactly one cycle.
- in_x=8'hFE (-2), in_y=8'h03 -> out_p=16'hFFFA; in_x=8'hFF, in_y=8'hFF -> out_p=16'h0001; in_x=in_y=8'h80 -> out_p=16'h4000.
- SIGNED=0, in_x=8'hFF, in_y=8'hFF -> out_p=16'hFE01; spm_y=0 for cycles 8..15 of SHIFT.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and out_p stable, in_ready=0, a new in_valid is ignored; release -> in_ready=1 on the next edge.
- rst pulsed low at SHIFT cycle 5 -> all outputs 0 immediately; after release, in_ready=1 next edge; next operation 7*9 -> out_p=16'h003F.
- Two back-to-back operations with in_valid held high -> second accept exactly one cycle after DONE exit; results correct and independent (no residue from the first product).
